// File: rtl/bus_responder_if.sv
// Processor data-bus bundle: address, write data, write strobe and read data.
interface bus_responder_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dout;
  logic              w;
  logic [DATA_W-1:0] din;

  modport master (output addr, dout, w, input din);
  modport slave  (input addr, dout, w, output din);
endinterface

// File: rtl/bus_responder.sv
// Memory-side responder for the processor data bus: RAM, LED/SW ports, write
// counter and a loader port. Read data returns one clock after the address.
module bus_responder #(
  parameter int DATA_W    = 10,
  parameter int ADDR_W    = 10,
  parameter int RAM_DEPTH = 128
) (
  input  logic              clock,
  input  logic              reset,
  bus_responder_if.slave    bus,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] led,
  output logic [DATA_W-1:0] wr_count,
  output logic              bad_access
);
  localparam int                RAM_AW   = $clog2(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] RAM_TOP  = ADDR_W'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(256);
  localparam logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(257);
  localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(258);

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + DATA_W'(1);
  endfunction

  logic [DATA_W-1:0] ram [RAM_DEPTH];

  logic              proc_in_ram;
  logic              load_in_ram;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_widx;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] rd_val_p0;
  logic [DATA_W-1:0] din_p1;

  // Full-width range checks keep high address bits from aliasing into RAM.
  assign proc_in_ram = (bus.addr < RAM_TOP);
  assign load_in_ram = (load_addr < RAM_TOP);

  // Stage p0: decode the write source (loader wins) and the read value.
  always_comb begin
    ram_we    = 1'b0;
    ram_widx  = bus.addr[RAM_AW-1:0];
    ram_wdata = bus.dout;
    if (!reset) begin
      if (load_en) begin
        ram_we    = load_in_ram;
        ram_widx  = load_addr[RAM_AW-1:0];
        ram_wdata = load_data;
      end else if (bus.w) begin
        ram_we    = proc_in_ram;
      end
    end
  end

  always_comb begin
    rd_val_p0 = '0;
    if (proc_in_ram)               rd_val_p0 = ram[bus.addr[RAM_AW-1:0]];
    else if (bus.addr == LED_ADDR) rd_val_p0 = led;
    else if (bus.addr == SW_ADDR)  rd_val_p0 = sw;
    else if (bus.addr == CNT_ADDR) rd_val_p0 = wr_count;
  end

  // Contents survive reset; read-first because the read sampled the old word.
  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_widx] <= ram_wdata;
  end

  // Stage p1: registered read data and control/status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      din_p1     <= '0;
      led        <= '0;
      wr_count   <= '0;
      bad_access <= 1'b0;
    end else begin
      din_p1 <= rd_val_p0;
      if (load_en) begin
        if (!load_in_ram) bad_access <= 1'b1;
      end else if (bus.w) begin
        if (proc_in_ram) begin
          wr_count <= sat_inc(wr_count);
        end else if (bus.addr == LED_ADDR) begin
          led      <= bus.dout;
          wr_count <= sat_inc(wr_count);
        end else begin
          bad_access <= 1'b1;
        end
      end
    end
  end

  assign bus.din = din_p1;
endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an address-map model.
module tb_bus_responder;
  localparam int DW = 10;
  localparam int AW = 10;
  localparam int DEPTH = 128;

  logic          clock = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic [DW-1:0] sw;
  logic [DW-1:0] led;
  logic [DW-1:0] wr_count;
  logic          bad_access;

  bus_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  bus_responder #(.DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .sw         (sw),
    .led        (led),
    .wr_count   (wr_count),
    .bad_access (bad_access)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory map as plain arrays, updated at each rising edge.
  int m_ram [DEPTH];
  bit m_known [DEPTH];
  int m_din, m_led, m_cnt;
  bit m_bad, m_din_known;
  bit chk_en = 1'b0;

  always @(posedge clock) begin
    int a, la;
    a  = int'(bus.addr);
    la = int'(load_addr);
    if (reset) begin
      m_din = 0; m_led = 0; m_cnt = 0; m_bad = 0;
      m_din_known = 1; chk_en = 1;
    end else begin
      m_din_known = 1;
      if (a < DEPTH) begin
        m_din = m_ram[a]; m_din_known = m_known[a];
      end else if (a == 'h100) m_din = m_led;
      else if (a == 'h101) m_din = int'(sw);
      else if (a == 'h102) m_din = m_cnt;
      else m_din = 0;
      if (load_en) begin
        if (la < DEPTH) begin
          m_ram[la] = int'(load_data); m_known[la] = 1;
        end else m_bad = 1;
      end else if (bus.w) begin
        if (a < DEPTH) begin
          m_ram[a] = int'(bus.dout);
          if (m_cnt < 1023) m_cnt++;
        end else if (a == 'h100) begin
          m_led = int'(bus.dout);
          if (m_cnt < 1023) m_cnt++;
        end else m_bad = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      if (m_din_known) check("din", int'(bus.din), m_din);
      check("led", int'(led), m_led);
      check("wr_count", int'(wr_count), m_cnt);
      check("bad_access", int'(bad_access), int'(m_bad));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.w = 0; load_en = 0;
  endtask

  initial begin
    reset = 1; bus.addr = 0; bus.dout = 0; bus.w = 0;
    load_en = 0; load_addr = 0; load_data = 0; sw = 10'h1A5;
    tick(); tick();
    reset = 0;
    check("rst_din", int'(bus.din), 0);
    check("rst_led", int'(led), 0);
    check("rst_cnt", int'(wr_count), 0);
    check("rst_bad", int'(bad_access), 0);

    // Loader write then processor read of address 5.
    load_en = 1; load_addr = 5; load_data = 10'h155; tick();
    idle(); bus.addr = 5; tick();
    check("load_read", int'(bus.din), 'h155);
    check("load_cnt", int'(wr_count), 0);

    // LED write then read back.
    bus.w = 1; bus.addr = 10'h100; bus.dout = 10'h2AA; tick();
    idle();
    check("led_wr", int'(led), 'h2AA);
    check("led_cnt", int'(wr_count), 1);
    tick();
    check("led_read", int'(bus.din), 'h2AA);

    // Read-first on RAM.
    load_en = 1; load_addr = 7; load_data = 10'h001; tick();
    idle(); bus.w = 1; bus.addr = 7; bus.dout = 10'h0F0; tick();
    check("rf_old", int'(bus.din), 'h001);
    idle(); tick();
    check("rf_new", int'(bus.din), 'h0F0);
    check("rf_cnt", int'(wr_count), 2);

    // Loader priority over a simultaneous processor write.
    load_en = 1; load_addr = 3; load_data = 10'h011;
    bus.w = 1; bus.addr = 3; bus.dout = 10'h3FF; tick();
    idle(); tick();
    check("prio_data", int'(bus.din), 'h011);
    check("prio_cnt", int'(wr_count), 2);
    check("prio_bad", int'(bad_access), 0);

    // Illegal write, unmapped read, SW read, then reset clears the flag.
    bus.w = 1; bus.addr = 10'h101; bus.dout = 10'h3C3; tick();
    idle(); bus.addr = 10'h200; tick();
    check("bad_set", int'(bad_access), 1);
    check("unmapped", int'(bus.din), 0);
    bus.addr = 10'h101; tick();
    check("sw_read", int'(bus.din), 'h1A5);
    check("bad_sticky", int'(bad_access), 1);
    bus.addr = 10'h102; tick();
    check("cnt_read", int'(bus.din), 2);
    reset = 1; tick(); reset = 0;
    check("bad_clr", int'(bad_access), 0);

    // Saturation of the write counter.
    bus.addr = 10'h100;
    for (int i = 0; i < 1023; i++) begin
      bus.w = 1; bus.dout = DW'(i); tick();
    end
    idle();
    check("sat_1023", int'(wr_count), 'h3FF);
    bus.w = 1; bus.dout = 10'h055; tick();
    check("sat_hold", int'(wr_count), 'h3FF);
    check("sat_led", int'(led), 'h055);
    reset = 1; bus.w = 1; bus.addr = 10'h100; bus.dout = 10'h123; tick();
    reset = 0; idle();
    check("mid_rst_led", int'(led), 0);
    check("mid_rst_cnt", int'(wr_count), 0);
    check("mid_rst_din", int'(bus.din), 0);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      bus.addr = AW'($urandom_range(0, DEPTH - 1));
      else if (sel == 6) bus.addr = 10'h100;
      else if (sel == 7) bus.addr = 10'h101;
      else if (sel == 8) bus.addr = 10'h102;
      else               bus.addr = AW'($urandom_range(DEPTH, 1023));
      bus.dout  = DW'($urandom);
      bus.w     = ($urandom_range(0, 9) < 4);
      load_en   = ($urandom_range(0, 19) < 3);
      load_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 1023))
                                              : AW'($urandom_range(0, DEPTH - 1));
      load_data = DW'($urandom);
      sw        = DW'($urandom);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0; idle(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Memory-side responder for the processor's data bus: services the ADDR / DOUT / W requests issued by the processor control path.
- Returns read data on DIN one clock after the address is presented.
- Decodes a small address map: synchronous RAM, an LED output register, a switch input port and a write-count status register.
- Provides a loader port so a program can be written into RAM while the processor is held in reset.

Parameters:
DATA_W, 10, data/instruction word width
ADDR_W, 10, processor address width
RAM_DEPTH, 128, RAM words mapped at addresses 0..RAM_DEPTH-1 (power of two, <= 256)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
addr  input  ADDR_W  address from processor ADDR register
dout  input  DATA_W  write data from processor DOUT register
w  input  1  processor write strobe, one cycle per store
din  output  DATA_W  registered read data to processor
load_en  input  1  loader write strobe
load_addr  input  ADDR_W  loader address (RAM region only)
load_data  input  DATA_W  loader write data
sw  input  DATA_W  switch inputs
led  output  DATA_W  LED register
wr_count  output  DATA_W  count of accepted processor writes
bad_access  output  1  sticky flag for an illegal or unmapped access

Behaviour:
Address map:
- 0..RAM_DEPTH-1: RAM, read/write.
- 0x100: LED register, read/write.
- 0x101: SW port, read-only; sampled value of sw.
- 0x102: wr_count, read-only.
- All other addresses are unmapped.

Reset (reset=1 at a rising edge):
- din=0, led=0, wr_count=0, bad_access=0.
- RAM contents are not cleared.
- Reset overrides any simultaneous w or load_en; nothing is written in that cycle.

Read path:
- Every cycle, din <= read value of the current addr.
- Latency is exactly 1 clock.
- Unmapped addresses read as 0.
- RAM is read-first: when the same address is written in the same cycle, din shows the old word; the new word is visible from the next cycle.
- LED reads follow the same rule and return the old value on a same-cycle write.

Processor write (w=1):
- RAM address: word <= dout; wr_count increments.
- 0x100: led <= dout; wr_count increments.
- 0x101, 0x102 or an unmapped address: write ignored, bad_access <= 1, wr_count unchanged.

Loader write (load_en=1):
- load_addr inside RAM: RAM[load_addr] <= load_data.
- load_addr outside RAM: ignored, bad_access <= 1.
- Loader writes never change wr_count.

Simultaneous load_en and w:
- Loader has priority.
- The processor write is dropped entirely: no RAM/LED update and no wr_count increment.
- bad_access is set only by the loader's own address check.

wr_count:
- Saturates at 2^DATA_W-1; no wrap.

bad_access:
- Sticky; cleared only by reset.

Address widths:
- RAM index = addr[log2(RAM_DEPTH)-1:0], used only after a full-width range check, so no aliasing.

Timing:
- No combinational path from inputs to din, led or wr_count; all outputs are registered.

Test Plan:
- Reset, then load_en writes 0x155 to address 5; processor presents addr=5 -> din=0x155 one clock later; wr_count=0.
- w=1, addr=0x100, dout=0x2AA -> led=0x2AA next cycle, wr_count=1; read addr=0x100 in the following cycle -> din=0x2AA.
- w=1, addr=7, dout=0x0F0 while RAM[7]=0x001 -> din=0x001 on that read, 0x0F0 on the next cycle.
- load_en and w asserted together with addr=3/dout=0x3FF and load_addr=3/load_data=0x011 -> RAM[3]=0x011, wr_count unchanged.
- w=1 to addr=0x101, then a read of addr=0x200 -> bad_access=1 and stays 1, din=0, sw read at 0x101 returns the sw value; reset clears bad_access.
- Force 1023 writes, then one more -> wr_count holds 0x3FF; reset asserted mid-sequence with w=1 -> led, wr_count and din all return to 0.
